// File: rtl/ram_rw_resp.sv
// rtl/ram_rw_resp.sv - single-outstanding ram_rw_* responder driving a RAMHelper-style memory
// Optional RAM_RW_ERR_EN adds ram_rw_err_o with range/alignment checking at acceptance.
module ram_rw_resp #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ram_rw_cen_i,
  input  logic             ram_rw_wen_i,
  input  logic [63:0]      ram_rw_addr_i,
  input  logic [63:0]      ram_rw_wdata_i,
  input  logic [7:0]       ram_rw_wmask_i,
  input  logic [2:0]       ram_rw_size_i,
  output logic             ram_rw_ready_o,
  output logic [63:0]      ram_rw_data_o,
`ifdef RAM_RW_ERR_EN
  output logic             ram_rw_err_o,
`endif
  output logic             mem_en_o,
  output logic             mem_wen_o,
  output logic [IDX_W-1:0] mem_idx_o,
  output logic [63:0]      mem_wdata_o,
  output logic [63:0]      mem_wmask_o,
  input  logic [63:0]      mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic        wen_q;
  logic        err_q;
  logic [3:0]  cnt;
  logic [63:0] data_q;
  logic [63:0] word_off;
  logic [63:0] wmask_bits;
  logic [63:0] rd_word;
  logic        req_err;

  always_comb begin
    word_off   = (ram_rw_addr_i - BASE_ADDR) >> 3;
    wmask_bits = '0;
    for (int i = 0; i < 8; i++) begin
      wmask_bits[i*8 +: 8] = {8{ram_rw_wmask_i[i]}};
    end
  end

  // Memory data is only valid in the first WAIT cycle; later cycles reuse the capture.
  assign rd_word = (cnt == WAIT_INIT) ? mem_rdata_i : data_q;

`ifdef RAM_RW_ERR_EN
  always_comb begin
    req_err = 1'b0;
    if (ram_rw_addr_i < BASE_ADDR) req_err = 1'b1;
    if ((word_off >> IDX_W) != 64'd0) req_err = 1'b1;
    case (ram_rw_size_i)
      3'd0:    ;
      3'd1:    if (ram_rw_addr_i[0] != 1'b0) req_err = 1'b1;
      3'd2:    if (ram_rw_addr_i[1:0] != 2'd0) req_err = 1'b1;
      3'd3:    if (ram_rw_addr_i[2:0] != 3'd0) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end
`else
  logic unused_bits;
  assign req_err     = 1'b0;
  assign unused_bits = ^{ram_rw_size_i, word_off[63:IDX_W]};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      wen_q          <= 1'b0;
      err_q          <= 1'b0;
      cnt            <= 4'd0;
      data_q         <= 64'd0;
      ram_rw_ready_o <= 1'b0;
      ram_rw_data_o  <= 64'd0;
      mem_en_o       <= 1'b0;
      mem_wen_o      <= 1'b0;
      mem_idx_o      <= '0;
      mem_wdata_o    <= 64'd0;
      mem_wmask_o    <= 64'd0;
`ifdef RAM_RW_ERR_EN
      ram_rw_err_o   <= 1'b0;
`endif
    end else begin
      ram_rw_ready_o <= 1'b0;
      ram_rw_data_o  <= 64'd0;
      mem_en_o       <= 1'b0;
      mem_wen_o      <= 1'b0;
      mem_idx_o      <= '0;
      mem_wdata_o    <= 64'd0;
      mem_wmask_o    <= 64'd0;
`ifdef RAM_RW_ERR_EN
      ram_rw_err_o   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (ram_rw_cen_i) begin
            // ACCESS-cycle memory outputs are registered here so they hold the latched request.
            wen_q <= ram_rw_wen_i;
            err_q <= req_err;
            state <= S_ACCESS;
            if (!req_err) begin
              mem_en_o    <= 1'b1;
              mem_wen_o   <= ram_rw_wen_i;
              mem_idx_o   <= word_off[IDX_W-1:0];
              mem_wdata_o <= ram_rw_wdata_i;
              mem_wmask_o <= wmask_bits;
            end
          end
        end
        S_ACCESS: begin
          cnt   <= WAIT_INIT;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == WAIT_INIT) data_q <= (wen_q || err_q) ? 64'd0 : mem_rdata_i;
          if (cnt == 4'd0) begin
            state          <= S_RESP;
            ram_rw_ready_o <= 1'b1;
            ram_rw_data_o  <= (wen_q || err_q) ? 64'd0 : rd_word;
`ifdef RAM_RW_ERR_EN
            ram_rw_err_o   <= err_q;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
